// File: rtl/nios2_vjtag_scan_master.sv
// nios2_vjtag_scan_master: virtual-JTAG initiator doing one IR update plus one full DR scan per command.
// Flags and state change only on the clk edge that drops vji_tck, so they are stable at every tck rise.
module nios2_vjtag_scan_master #(
  parameter int DR_LEN     = 38,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_data,
  output logic              vji_tck,
  output logic              vji_tdi,
  input  logic              vji_tdo,
  output logic [1:0]        vji_ir_in,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic              vji_rti
);
  localparam int DW   = $clog2(TCK_DIV + 1);
  localparam int CMAX = DR_LEN > RTI_CYCLES ? DR_LEN : RTI_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RESP} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              tck_q, tck_d;
  logic [1:0]        ir_q, ir_d;
  logic [DR_LEN-1:0] shift_q, shift_d, cap_q, cap_d;
  logic              active, half, rise, fall, last_sdr, last_rti;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      tck_q   <= 1'b0;
      ir_q    <= '0;
      shift_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tck_q   <= tck_d;
      ir_q    <= ir_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    active   = !(state_q == IDLE || state_q == RESP);
    half     = active && div_q == DW'(TCK_DIV - 1);
    rise     = half && !tck_q;
    fall     = half && tck_q;
    last_sdr = cnt_q == CW'(DR_LEN - 1);
    last_rti = cnt_q == CW'(RTI_CYCLES - 1);
    state_d  = state_q;
    div_d    = !active ? '0 : half ? '0 : div_q + 1'b1;
    tck_d    = half ? !tck_q : tck_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    shift_d  = shift_q;
    cap_d    = cap_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = UIR;
        ir_d    = cmd_ir;
        shift_d = cmd_data;
      end
      UIR: state_d = fall ? CDR : UIR;
      CDR: state_d = fall ? SDR : CDR;
      SDR: begin
        if (rise) cap_d = {vji_tdo, cap_q[DR_LEN-1:1]};
        if (fall) begin
          shift_d = shift_q >> 1;
          cnt_d   = last_sdr ? '0 : cnt_q + 1'b1;
          state_d = last_sdr ? UDR : SDR;
        end
      end
      UDR: state_d = fall ? RTI : UDR;
      RTI: if (fall) begin
        cnt_d   = last_rti ? '0 : cnt_q + 1'b1;
        state_d = last_rti ? RESP : RTI;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_data  = cap_q;
  assign vji_tck   = tck_q;
  assign vji_tdi   = state_q == SDR && shift_q[0];
  assign vji_ir_in = ir_q;
  assign vji_uir   = state_q == UIR;
  assign vji_cdr   = state_q == CDR;
  assign vji_sdr   = state_q == SDR;
  assign vji_udr   = state_q == UDR;
  assign vji_rti   = state_q == RTI;
endmodule
